// File: rtl/enable_mask_stack.sv
// Per-lane enable-mask stack for predicated execution: a live top-of-stack mask
// plus DEPTH saved masks, with ELSE support, occupancy count and sticky error flags.

module enable_mask_stack #(
    parameter int LANES = 8,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [LANES-1:0] lane_zero,
    input  logic             clr_err,
    output logic [LANES-1:0] en_mask,
    output logic             any_en,
    output logic [CW-1:0]    depth_cnt,
    output logic             ovf,
    output logic             unf
);

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_ALLEN  = 3'd1,
        OP_PUSHEN = 3'd2,
        OP_POPEN  = 3'd3,
        OP_JUMPF  = 3'd4,
        OP_ELSEEN = 3'd5
    } op_e;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [LANES-1:0] top_q, top_d;
    logic [LANES-1:0] save_q [DEPTH];
    logic [LANES-1:0] save_d [DEPTH];
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             any_q, any_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ovf_evt, unf_evt;
    logic [LANES-1:0] parent_mask;

    // With nothing saved the ELSE parent is the implicit all-enabled mask.
    assign parent_mask = (cnt_q == '0) ? '1 : save_q[0];

    always_comb begin
        top_d   = top_q;
        save_d  = save_q;
        cnt_d   = cnt_q;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (op_valid) begin
            case (op_e'(op))
                OP_ALLEN: begin
                    top_d = '1;
                end
                OP_PUSHEN: begin
                    for (int i = DEPTH - 1; i > 0; i--) begin
                        save_d[i] = save_q[i-1];
                    end
                    save_d[0] = top_q;
                    if (cnt_q == CNT_FULL) begin
                        ovf_evt = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                OP_POPEN: begin
                    if (cnt_q == '0) begin
                        top_d   = '1;
                        unf_evt = 1'b1;
                    end else begin
                        top_d = save_q[0];
                        for (int i = 0; i < DEPTH - 1; i++) begin
                            save_d[i] = save_q[i+1];
                        end
                        save_d[DEPTH-1] = '1;
                        cnt_d           = cnt_q - CNT_ONE;
                    end
                end
                OP_JUMPF: begin
                    top_d = top_q & ~lane_zero;
                end
                OP_ELSEEN: begin
                    top_d = parent_mask & ~top_q;
                end
                default: begin
                    top_d = top_q;
                end
            endcase
        end
    end

    // A new error event on the same edge as clr_err keeps the flag set.
    always_comb begin
        ovf_d = (ovf_q & ~clr_err) | ovf_evt;
        unf_d = (unf_q & ~clr_err) | unf_evt;
        any_d = |top_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top_q <= '1;
            for (int i = 0; i < DEPTH; i++) begin
                save_q[i] <= '1;
            end
            cnt_q <= '0;
            any_q <= 1'b1;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            top_q  <= top_d;
            save_q <= save_d;
            cnt_q  <= cnt_d;
            any_q  <= any_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign en_mask   = top_q;
    assign any_en    = any_q;
    assign depth_cnt = cnt_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: tb/tb_enable_mask_stack.sv
// Directed plus random stimulus for enable_mask_stack, checked against a
// queue-based stack model through an expected-result scoreboard.

module tb_enable_mask_stack;

    localparam int LANES = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             op_valid;
    logic [2:0]       op;
    logic [LANES-1:0] lane_zero;
    logic             clr_err;
    logic [LANES-1:0] en_mask;
    logic             any_en;
    logic [CW-1:0]    depth_cnt;
    logic             ovf;
    logic             unf;

    enable_mask_stack #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op        (op),
        .lane_zero (lane_zero),
        .clr_err   (clr_err),
        .en_mask   (en_mask),
        .any_en    (any_en),
        .depth_cnt (depth_cnt),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        logic [LANES-1:0] en;
        logic             any;
        logic [CW-1:0]    cnt;
        logic             ovf;
        logic             unf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: front of the queue is the entry nearest the top.
    logic [LANES-1:0] m_top;
    logic [LANES-1:0] m_stack[$];
    logic             m_ovf;
    logic             m_unf;

    task automatic modelStep(input bit rst, input bit vld, input logic [2:0] o,
                             input logic [LANES-1:0] lz, input bit clr);
        bit               oe;
        bit               ue;
        logic [LANES-1:0] parent;
        oe = 0;
        ue = 0;
        if (rst) begin
            m_top = '1;
            m_stack.delete();
            m_ovf = 0;
            m_unf = 0;
            return;
        end
        if (vld) begin
            case (o)
                3'd1: m_top = '1;
                3'd2: begin
                    m_stack.push_front(m_top);
                    if (m_stack.size() > DEPTH) begin
                        void'(m_stack.pop_back());
                        oe = 1;
                    end
                end
                3'd3: begin
                    if (m_stack.size() == 0) begin
                        m_top = '1;
                        ue    = 1;
                    end else begin
                        m_top = m_stack.pop_front();
                    end
                end
                3'd4: m_top = m_top & ~lz;
                3'd5: begin
                    parent = (m_stack.size() == 0) ? '1 : m_stack[0];
                    m_top  = parent & ~m_top;
                end
                default: ;
            endcase
        end
        if (clr) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (oe) m_ovf = 1;
        if (ue) m_unf = 1;
    endtask

    task automatic checkOutput();
        exp_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected>0");
            return;
        end
        e = sb.pop_front();
        total++;
        assert (en_mask === e.en) else begin
            bad++;
            $error("[TB] FAIL %s.en_mask observed=%h expected=%h", e.tag, en_mask, e.en);
        end
        total++;
        assert (any_en === e.any) else begin
            bad++;
            $error("[TB] FAIL %s.any_en observed=%b expected=%b", e.tag, any_en, e.any);
        end
        total++;
        assert (depth_cnt === e.cnt) else begin
            bad++;
            $error("[TB] FAIL %s.depth_cnt observed=%0d expected=%0d", e.tag, depth_cnt, e.cnt);
        end
        total++;
        assert (ovf === e.ovf) else begin
            bad++;
            $error("[TB] FAIL %s.ovf observed=%b expected=%b", e.tag, ovf, e.ovf);
        end
        total++;
        assert (unf === e.unf) else begin
            bad++;
            $error("[TB] FAIL %s.unf observed=%b expected=%b", e.tag, unf, e.unf);
        end
    endtask

    task automatic applyStimulus(input string tag, input bit rst, input bit vld,
                                 input logic [2:0] o, input logic [LANES-1:0] lz,
                                 input bit clr);
        exp_t e;
        @(negedge clk);
        reset     = rst;
        op_valid  = vld;
        op        = o;
        lane_zero = lz;
        clr_err   = clr;
        modelStep(rst, vld, o, lz, clr);
        e.tag = tag;
        e.en  = m_top;
        e.any = |m_top;
        e.cnt = CW'(m_stack.size());
        e.ovf = m_ovf;
        e.unf = m_unf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        reset     = 1'b1;
        op_valid  = 1'b0;
        op        = 3'd0;
        lane_zero = '0;
        clr_err   = 1'b0;
        m_top     = '1;
        m_ovf     = 0;
        m_unf     = 0;

        applyStimulus("reset", 1, 0, 3'd0, 8'h00, 0);
        applyStimulus("reset_op", 1, 1, 3'd3, 8'h00, 0);
        for (int i = 0; i < 3; i++) applyStimulus("idle", 0, 0, 3'd2, 8'hFF, 0);

        applyStimulus("if_push", 0, 1, 3'd2, 8'h00, 0);
        applyStimulus("if_jumpf", 0, 1, 3'd4, 8'h0F, 0);
        applyStimulus("if_else", 0, 1, 3'd5, 8'h00, 0);
        applyStimulus("if_pop", 0, 1, 3'd3, 8'h00, 0);

        for (int i = 0; i < 17; i++) applyStimulus("fill_push", 0, 1, 3'd2, 8'h00, 0);
        for (int i = 0; i < 16; i++) applyStimulus("drain_pop", 0, 1, 3'd3, 8'h00, 0);
        applyStimulus("clr_ovf", 0, 0, 3'd0, 8'h00, 1);

        applyStimulus("else_empty", 0, 1, 3'd5, 8'h00, 0);
        applyStimulus("allen", 0, 1, 3'd1, 8'h00, 0);
        applyStimulus("jumpf_3c", 0, 1, 3'd4, 8'hC3, 0);
        applyStimulus("pop_empty", 0, 1, 3'd3, 8'h00, 0);
        applyStimulus("clr_and_pop", 0, 1, 3'd3, 8'h00, 1);
        applyStimulus("clr_only", 0, 0, 3'd0, 8'h00, 1);

        applyStimulus("jumpf_all", 0, 1, 3'd4, 8'hFF, 0);
        applyStimulus("push_zero", 0, 1, 3'd2, 8'h00, 0);
        applyStimulus("allen_after", 0, 1, 3'd1, 8'h00, 0);
        applyStimulus("pop_zero", 0, 1, 3'd3, 8'h00, 0);
        applyStimulus("reserved6", 0, 1, 3'd6, 8'h00, 0);
        applyStimulus("reserved7", 0, 1, 3'd7, 8'h00, 0);

        for (int i = 0; i < 3; i++) applyStimulus("pre_reset_push", 0, 1, 3'd2, 8'h00, 0);
        applyStimulus("reset_pop", 1, 1, 3'd3, 8'h00, 0);

        for (int i = 0; i < 300; i++) begin
            applyStimulus("random", ($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
                          3'($urandom_range(0, 7)), 8'($urandom),
                          ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enable_mask_stack.md
Name: enable_mask_stack

Overview:
- Parametrised per-lane enable-mask stack for the pipelined processor's predicated-execution path.
- Generalises the single 32-bit enable stack to LANES independent lanes and DEPTH saved masks.
- Adds an ELSE operation, occupancy tracking and sticky overflow/underflow flags.
- Sits beside pipeline stage 2: an enabled lane's store, trap and register write-back commit only when its en_mask bit is 1.

Parameters:
- LANES, 8: number of SIMD lanes, which is the width of each mask.
- DEPTH, 16: number of saved masks below the top-of-stack; must be >= 1.
- CW, $clog2(DEPTH+1): derived width of depth_cnt; not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- op_valid  input  1  op is applied on this edge when high; ignored when low
- op  input  3  0 NOP, 1 ALLEN, 2 PUSHEN, 3 POPEN, 4 JUMPF, 5 ELSEEN, 6-7 reserved (treated as NOP)
- lane_zero  input  LANES  per-lane "tested register == 0", used by JUMPF only
- clr_err  input  1  clears ovf and unf
- en_mask  output  LANES  current top-of-stack mask, registered
- any_en  output  1  OR-reduction of en_mask, registered
- depth_cnt  output  CW  number of valid saved masks, 0..DEPTH
- ovf  output  1  sticky: a push was made while full
- unf  output  1  sticky: a pop was made while empty

Behaviour:
- State: top[LANES-1:0], save[0..DEPTH-1] (save[0] is nearest the top), cnt.
- Reset, synchronous, has priority over everything:
  - top and every save entry become all ones; cnt becomes 0; ovf and unf become 0.
  - Outputs on the next cycle are en_mask all ones, any_en 1, depth_cnt 0, ovf 0, unf 0.
- Reset in the middle of a program sequence discards all saved state.
- Outputs are registered: an op sampled at edge N is visible right after edge N. Latency is 1 cycle.
- Every op, including a back-to-back op, completes in one cycle. There is no ready signal and no stall.
- Ops applied when op_valid is 1:
  - NOP: no change.
  - ALLEN: top becomes all ones. Saves and cnt are unchanged.
  - PUSHEN:
    - save[i+1] takes save[i] for every i; save[0] takes top; top is unchanged (the mask is duplicated).
    - If cnt < DEPTH, cnt increments.
    - If cnt == DEPTH, the old save[DEPTH-1] is discarded, cnt stays at DEPTH and ovf is set.
  - POPEN with cnt > 0:
    - top takes save[0]; save[i] takes save[i+1].
    - save[DEPTH-1] becomes all ones.
    - cnt decrements.
  - POPEN with cnt == 0:
    - top becomes all ones, saves are unchanged, cnt stays 0 and unf is set.
  - JUMPF: top becomes top & ~lane_zero, i.e. lanes whose condition is zero are disabled. Saves and cnt are unchanged.
  - ELSEEN:
    - top becomes save[0] & ~top: lanes enabled in the parent mask but disabled now.
    - If cnt == 0, the parent is taken as all ones, so top becomes ~top.
- clr_err clears ovf and unf. If an overflow or underflow event happens on the same edge, setting wins.
- ovf and unf stay set until clr_err or reset.
- Ops do not depend on en_mask: a fully disabled top still pushes and pops normally.
- LANES == 1 must degenerate correctly, reproducing the original single-lane stack except for the ELSEEN, occupancy and error additions.

Test Plan:
- Reset, then idle 3 cycles with LANES=8 -> en_mask 0xFF, any_en 1, depth_cnt 0, ovf 0, unf 0.
- PUSHEN, JUMPF with lane_zero 0x0F, ELSEEN, POPEN -> en_mask 0xFF, then 0xF0, then 0x0F, then 0xFF; depth_cnt goes 1, 1, 1, 0.
- 17 PUSHENs with DEPTH=16 -> depth_cnt reaches 16, ovf goes 1 after the 17th push; 16 POPENs -> depth_cnt 0, unf 0.
- POPEN at depth 0 with top 0x3C -> en_mask 0xFF, unf 1. Then assert clr_err and POPEN on the same edge -> unf stays 1. Next cycle clr_err alone -> unf 0.
- JUMPF with lane_zero 0xFF -> en_mask 0x00, any_en 0. Then PUSHEN -> depth_cnt 1 while the mask stays 0x00. Then ALLEN -> 0xFF.
- PUSHEN x3, then reset asserted together with op_valid and POPEN -> after the edge, depth_cnt 0, en_mask 0xFF, unf 0.
